// File: rtl/sdram_req_arbiter.sv
// Shares one SDRAM controller command port among the sprite, background and CPU requesters.
// Fixed priority spr > bg > cpu; the CPU is forced to win after CPU_MAX_WAIT consecutive
// non-CPU grants while it is waiting. Every requester uses a one-cycle req / rdy pulse pair.
module sdram_req_arbiter #(
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned CPU_MAX_WAIT = 4
) (
  input  logic              CLK_96M,
  input  logic              reset,
  // sprite fetch, 64-bit
  input  logic              spr_req,
  input  logic [ADDR_W-1:0] spr_addr,
  output logic [63:0]       spr_dout,
  output logic              spr_rdy,
  // background tile fetch, 32-bit
  input  logic              bg_req,
  input  logic [ADDR_W-1:0] bg_addr,
  output logic [31:0]       bg_dout,
  output logic              bg_rdy,
  // CPU access, 16-bit read/write
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_din,
  input  logic [1:0]        cpu_wr_sel,
  output logic [15:0]       cpu_dout,
  output logic              cpu_rdy,
  // SDRAM controller command port
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_size,
  output logic [1:0]        mem_wr_sel,
  output logic [15:0]       mem_din,
  input  logic [63:0]       mem_dout,
  input  logic              mem_rdy,
  // status
  output logic              busy,
  output logic [1:0]        grant,
  output logic [2:0]        overrun
);

  localparam int unsigned     CntW    = (CPU_MAX_WAIT < 1) ? 1 : $clog2(CPU_MAX_WAIT + 1);
  localparam logic [CntW-1:0] MaxWait = CntW'(CPU_MAX_WAIT);

  localparam logic [1:0] GntNone = 2'd0;
  localparam logic [1:0] GntSpr  = 2'd1;
  localparam logic [1:0] GntBg   = 2'd2;
  localparam logic [1:0] GntCpu  = 2'd3;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e            state_q;
  logic [2:0]        pend_q;       // {cpu, bg, spr}
  logic [ADDR_W-1:0] spr_addr_q;
  logic [ADDR_W-1:0] bg_addr_q;
  logic [ADDR_W-1:0] cpu_addr_q;
  logic [15:0]       cpu_din_q;
  logic [1:0]        cpu_wr_sel_q;
  logic [CntW-1:0]   wait_cnt_q;

  logic [2:0] req_vec;
  logic [2:0] take_vec;
  logic [2:0] win_vec;
  logic [1:0] win;

  assign req_vec = {cpu_req, bg_req, spr_req};

  // A channel holds one request at a time; a req while pending or in service is dropped.
  assign take_vec[0] = spr_req & ~pend_q[0] & (grant != GntSpr);
  assign take_vec[1] = bg_req  & ~pend_q[1] & (grant != GntBg);
  assign take_vec[2] = cpu_req & ~pend_q[2] & (grant != GntCpu);

  // Pick the winner from registered pending flags only, with CPU escalation first.
  always_comb begin
    win = GntNone;
    if (state_q == StIdle) begin
      if (pend_q[2] && (wait_cnt_q == MaxWait)) begin
        win = GntCpu;
      end else if (pend_q[0]) begin
        win = GntSpr;
      end else if (pend_q[1]) begin
        win = GntBg;
      end else if (pend_q[2]) begin
        win = GntCpu;
      end
    end
  end

  assign win_vec = {win == GntCpu, win == GntBg, win == GntSpr};

  // Request capture: slots, pending flags and sticky overrun flags.
  always_ff @(posedge CLK_96M or posedge reset) begin
    if (reset) begin
      pend_q       <= 3'b000;
      spr_addr_q   <= '0;
      bg_addr_q    <= '0;
      cpu_addr_q   <= '0;
      cpu_din_q    <= 16'h0000;
      cpu_wr_sel_q <= 2'b00;
      overrun      <= 3'b000;
    end else begin
      // Winner is always pending, so it can never be re-captured on its grant edge.
      pend_q  <= (pend_q & ~win_vec) | take_vec;
      overrun <= overrun | (req_vec & ~take_vec);
      if (take_vec[0]) begin
        spr_addr_q <= spr_addr;
      end
      if (take_vec[1]) begin
        bg_addr_q <= bg_addr;
      end
      if (take_vec[2]) begin
        cpu_addr_q   <= cpu_addr;
        cpu_din_q    <= cpu_din;
        cpu_wr_sel_q <= cpu_wr_sel;
      end
    end
  end

  // Command FSM with registered controller outputs, completion pulses and wait counter.
  always_ff @(posedge CLK_96M or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      grant      <= GntNone;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_size   <= 2'd0;
      mem_wr_sel <= 2'b00;
      mem_din    <= 16'h0000;
      spr_dout   <= 64'h0;
      bg_dout    <= 32'h0;
      cpu_dout   <= 16'h0;
      spr_rdy    <= 1'b0;
      bg_rdy     <= 1'b0;
      cpu_rdy    <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      mem_req <= 1'b0;
      spr_rdy <= 1'b0;
      bg_rdy  <= 1'b0;
      cpu_rdy <= 1'b0;

      case (state_q)
        StIdle: begin
          if (win != GntNone) begin
            mem_req <= 1'b1;
            grant   <= win;
            state_q <= StWait;
            case (win)
              GntSpr: begin
                mem_addr   <= spr_addr_q;
                mem_size   <= 2'd2;
                mem_wr_sel <= 2'b00;
                mem_din    <= 16'h0000;
              end
              GntBg: begin
                mem_addr   <= bg_addr_q;
                mem_size   <= 2'd1;
                mem_wr_sel <= 2'b00;
                mem_din    <= 16'h0000;
              end
              default: begin
                mem_addr   <= cpu_addr_q;
                mem_size   <= 2'd0;
                mem_wr_sel <= cpu_wr_sel_q;
                mem_din    <= cpu_din_q;
              end
            endcase
          end
        end
        StWait: begin
          if (mem_rdy) begin
            case (grant)
              GntSpr: begin
                spr_dout <= mem_dout;
                spr_rdy  <= 1'b1;
              end
              GntBg: begin
                bg_dout <= mem_dout[31:0];
                bg_rdy  <= 1'b1;
              end
              GntCpu: begin
                cpu_dout <= mem_dout[15:0];
                cpu_rdy  <= 1'b1;
              end
              default: ;
            endcase
            grant   <= GntNone;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Count non-CPU grants taken while the CPU waits; saturate at the escalation point.
      if ((win == GntCpu) || !pend_q[2]) begin
        wait_cnt_q <= '0;
      end else if (((win == GntSpr) || (win == GntBg)) && (wait_cnt_q != MaxWait)) begin
        wait_cnt_q <= wait_cnt_q + CntW'(1);
      end
    end
  end

  assign busy = (state_q != StIdle);

endmodule
